// File: rtl/pin_auth.sv
// PIN entry and authentication controller for a card reader: collects four BCD
// digits, compares them with the card's stored PIN and tracks remaining attempts.
module pin_auth #(
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        card_in,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        clear,
  input  logic        enter,
  input  logic [15:0] stored_pin,
  output logic        auth_ok,
  output logic        auth_fail,
  output logic        card_retain,
  output logic        timeout,
  output logic [2:0]  digit_cnt,
  output logic [1:0]  tries_left
);

  localparam int unsigned TimerW     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYC - 1);
  localparam logic [1:0]        TriesInit = 2'(MAX_TRIES);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StCheck,
    StGranted,
    StDenied,
    StLocked
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         entry_q, entry_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [1:0]          tries_q, tries_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                digit_ok;

  assign digit_ok = digit_valid && (digit <= 4'd9) && (cnt_q < 3'd4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      entry_q <= '0;
      cnt_q   <= '0;
      tries_q <= TriesInit;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    timer_d = timer_q;
    timeout = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (card_in) begin
          state_d = StCollect;
          tries_d = TriesInit;
          cnt_d   = '0;
          entry_d = '0;
          timer_d = '0;
        end
      end

      StCollect: begin
        if (!card_in) begin
          state_d = StIdle;
          cnt_d   = '0;
          entry_d = '0;
          timer_d = '0;
        end else if (enter && (cnt_q == 3'd4)) begin
          state_d = StCheck;
        end else if (!enter && clear) begin
          cnt_d   = '0;
          entry_d = '0;
          timer_d = '0;
        end else if (!enter && !clear && digit_ok) begin
          entry_d = {entry_q[11:0], digit};
          cnt_d   = cnt_q + 3'd1;
          timer_d = '0;
        end else if (timer_q == TimerLast) begin
          // Ignored digits and short enters fall through here: they are not activity.
          timeout = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
          entry_d = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      StCheck: begin
        if (!card_in) begin
          state_d = StIdle;
          cnt_d   = '0;
          entry_d = '0;
        end else if (entry_q == stored_pin) begin
          state_d = StGranted;
        end else begin
          cnt_d   = '0;
          entry_d = '0;
          if (tries_q <= 2'd1) begin
            tries_d = '0;
            state_d = StLocked;
          end else begin
            tries_d = tries_q - 2'd1;
            state_d = StDenied;
          end
        end
      end

      StGranted: begin
        if (!card_in) begin
          state_d = StIdle;
          cnt_d   = '0;
          entry_d = '0;
        end
      end

      StDenied: begin
        state_d = card_in ? StCollect : StIdle;
        timer_d = '0;
      end

      StLocked: ;

      default: state_d = StIdle;
    endcase
  end

  assign auth_ok     = (state_q == StGranted);
  assign auth_fail   = (state_q == StDenied) && card_in;
  assign card_retain = (state_q == StLocked);
  assign digit_cnt   = cnt_q;
  assign tries_left  = tries_q;

endmodule

// File: doc/pin_auth.md
PIN_AUTH -- requirements
Module: pin_auth

Interface
REQ-001 Parameter MAX_TRIES, default 3: wrong-PIN attempts allowed per card session before the card is retained.
REQ-002 Parameter TIMEOUT_CYC, default 1024: idle cycles allowed in COLLECT before the session is abandoned.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 card_in  input  1  level; card present in slot.
REQ-006 digit_valid  input  1  one-cycle strobe; digit is valid this cycle.
REQ-007 digit  input  4  keypad code; 0-9 are digits, 10-15 are not digits.
REQ-008 clear  input  1  one-cycle strobe; discard the digits entered so far.
REQ-009 enter  input  1  one-cycle strobe; submit the PIN.
REQ-010 stored_pin  input  16  4 BCD digits; [15:12] is the first digit; stable while card_in=1.
REQ-011 auth_ok  output  1  level; PIN accepted; drives the downstream correctPassword input.
REQ-012 auth_fail  output  1  one-cycle pulse; wrong PIN entered, tries remain.
REQ-013 card_retain  output  1  level; tries exhausted, card is kept.
REQ-014 timeout  output  1  one-cycle pulse; session abandoned because of inactivity.
REQ-015 digit_cnt  output  3  digits held, 0-4; drives the masked display.
REQ-016 tries_left  output  2  remaining attempts.

Function
REQ-017 The FSM SHALL have the states IDLE, COLLECT, CHECK, GRANTED, DENIED and LOCKED.
REQ-018 IDLE: when card_in=1 the FSM SHALL go to COLLECT, set tries_left=MAX_TRIES, set digit_cnt=0, clear the entry register and clear the timer.
REQ-019 COLLECT, accepting a digit: if digit_valid=1, digit<=9 and digit_cnt<4, the block SHALL shift the digit into the entry register (first digit ends in [15:12]) and increment digit_cnt.
REQ-020 COLLECT, ignored digits: the block SHALL ignore non-digit codes and any 5th or later digit; an ignored digit SHALL NOT reset the timer.
REQ-021 COLLECT, clear: clear=1 SHALL set digit_cnt=0 and the entry register to 0.
REQ-022 COLLECT, enter: enter=1 with digit_cnt=4 SHALL move the FSM to CHECK; enter=1 with digit_cnt<4 SHALL be ignored.
REQ-023 Priority in the same cycle SHALL be enter > clear > digit_valid; the lower-priority events are dropped.
REQ-024 Timer: the timer SHALL count cycles in COLLECT and SHALL clear on an accepted digit, on clear, and on entry to COLLECT.
REQ-025 Timeout: when the timer reaches TIMEOUT_CYC-1, the block SHALL pulse timeout for one cycle and go to IDLE.
REQ-026 CHECK lasts one cycle, on a match: entry==stored_pin SHALL move the FSM to GRANTED.
REQ-027 CHECK, on a mismatch: tries_left SHALL decrement; if the result is 0 the FSM SHALL go to LOCKED, otherwise to DENIED.
REQ-028 GRANTED: auth_ok=1 SHALL be held while card_in=1; card_in=0 SHALL return the FSM to IDLE with auth_ok=0 in the next cycle.
REQ-029 DENIED: auth_fail=1 for one cycle, digit_cnt=0 and entry register=0; the FSM then returns to COLLECT with the timer cleared.
REQ-030 LOCKED: card_retain=1 SHALL be held and all inputs SHALL be ignored until reset.
REQ-031 card_in=0 in COLLECT, CHECK or DENIED SHALL return the FSM to IDLE in the next cycle, with no auth_fail and no timeout.
REQ-032 Latency: enter sampled at edge N puts the FSM in CHECK after edge N; auth_ok, auth_fail or card_retain is asserted after edge N+1.
REQ-033 The entry register SHALL NOT be observable at any output.

Reset
REQ-034 On reset=1 the block SHALL go to IDLE immediately, at any time, with auth_ok=0, auth_fail=0, card_retain=0, timeout=0, digit_cnt=0, tries_left=MAX_TRIES, entry register=0 and timer=0.
REQ-035 Reset asserted in the middle of a session SHALL discard all partial entry; LOCKED is left only by reset.

Verification
REQ-036 Correct PIN: stored_pin=16'h1234, card_in=1, digits 1,2,3,4, then enter -> auth_ok=1 two edges after enter; card_in=0 -> auth_ok=0 one cycle later.
REQ-037 Wrong then right: enter 1,2,3,5 -> auth_fail pulse and tries_left=2; then enter 1,2,3,4 -> auth_ok=1.
REQ-038 Lockout: three wrong PINs -> two auth_fail pulses, then card_retain=1 and tries_left=0; further digits and card_in toggles have no effect until reset.
REQ-039 Edge inputs: digit=4'hB is ignored; enter at digit_cnt=3 is ignored; a 5th digit is ignored; enter and digit_valid in the same cycle -> CHECK with the 4-digit entry.
REQ-040 Timeout with TIMEOUT_CYC=16: enter 2 digits, then 16 idle cycles -> one timeout pulse, FSM in IDLE, digit_cnt=0.
REQ-041 Reset in mid-entry after 3 digits -> all outputs at reset values; a new session starts with tries_left=3.
